// File: rtl/sys_cmd_pkg.sv
// Shared types and widths for the system-side command master.
package sys_cmd_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } sys_cmd_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sys_cmd_t;

endpackage

// File: rtl/sys_cmd_fifo.sv
// Synchronous request FIFO of sys_cmd_t with async active-high reset.
module sys_cmd_fifo
  import sys_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  sys_cmd_t               din,
  output sys_cmd_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sys_cmd_t        mem_q [DEPTH];
  sys_cmd_t        mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when the same cycle pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sys_cmd_master.sv
// System-side initiator: buffers requests and drives the controller command handshake.
// Define SYS_CMD_TIMEOUT_EN to enable the per-command watchdog (rsp_err).
module sys_cmd_master
  import sys_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              we_sys,
  output logic              cmd_valid_sys,
  output logic [ADDR_W-1:0] addr_sys,
  inout  wire  [DATA_W-1:0] data_sys,
  input  logic              ready_sys,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  sys_cmd_state_e            state_q, state_d;
  sys_cmd_t                  cmd_q, cmd_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_we_q, rsp_we_d;
  logic [ADDR_W-1:0]         rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0]         rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  sys_cmd_t                  fifo_dout, fifo_din;
  logic                      tmo_hit;

  assign fifo_din = '{we: req_we, addr: req_addr, wdata: req_wdata};

  sys_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (req_valid),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef SYS_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // tmo_cnt_d is the number of ISSUE cycles including the current one.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ISSUE) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_d = '0;
    end
  end

  assign tmo_hit = (state_q == ISSUE) && (tmo_cnt_d == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          cmd_d       = fifo_dout;
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // A completion in the expiry cycle beats the watchdog.
        if (ready_sys || tmo_hit) begin
          cmd_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = cmd_q.we;
          rsp_addr_d  = cmd_q.addr;
          rsp_rdata_d = (ready_sys && !cmd_q.we) ? data_sys : '0;
          rsp_err_d   = !ready_sys;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        cmd_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready     = !fifo_full;
  assign cmd_valid_sys = cmd_valid_q;
  assign we_sys        = cmd_q.we;
  assign addr_sys      = cmd_q.addr;
  assign data_sys      = (cmd_valid_q && cmd_q.we) ? cmd_q.wdata : 'z;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_we        = rsp_we_q;
  assign rsp_addr      = rsp_addr_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_sys_cmd_master.sv
// Self-checking bench for sys_cmd_master: controller model plus response scoreboard.
module tb_sys_cmd_master;
  import sys_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready, we_sys, cmd_valid_sys;
  logic [7:0] addr_sys;
  wire  [7:0] data_sys;
  logic       ready_sys;
  logic       rsp_valid, rsp_we, rsp_err, busy;
  logic [7:0] rsp_addr, rsp_rdata;

  logic       ctl_drive;
  logic [7:0] ctl_data;
  logic       ctl_en, ctl_stray;
  int         ctl_delay;
  logic [7:0] ctl_mem [256];
  logic [7:0] shadow  [256];

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  assign data_sys = ctl_drive ? ctl_data : 8'hzz;

  always #5 clk = ~clk;

  sys_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .we_sys        (we_sys),
    .cmd_valid_sys (cmd_valid_sys),
    .addr_sys      (addr_sys),
    .data_sys      (data_sys),
    .ready_sys     (ready_sys),
    .rsp_valid     (rsp_valid),
    .rsp_we        (rsp_we),
    .rsp_addr      (rsp_addr),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .busy          (busy)
  );

  // Controller model: completes a command ctl_delay ISSUE cycles after it appears.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    ready_sys = 1'b0;
    ctl_drive = 1'b0;
    ctl_data  = 8'h00;
    forever begin
      @(negedge clk);
      ready_sys = ctl_stray;
      ctl_drive = 1'b0;
      if (ctl_en && cmd_valid_sys && !reset) begin
        if (wait_cnt == ctl_delay) begin
          ready_sys = 1'b1;
          if (we_sys) begin
            ctl_mem[addr_sys] = data_sys;
          end else begin
            ctl_drive = 1'b1;
            ctl_data  = ctl_mem[addr_sys];
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response scoreboard.
  initial begin
    logic rsp_prev;
    exp_t e;
    rsp_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rsp_prev = 1'b0;
      end else begin
        if (rsp_valid) begin
          checks++;
          if (rsp_prev) begin
            errors++;
            $display("FAIL rsp_pulse: rsp_valid high for a second cycle, required a single-cycle pulse");
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got we=%0b addr=%h rdata=%h, required no response",
                     rsp_we, rsp_addr, rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            if ({rsp_we, rsp_addr, rsp_rdata, rsp_err} !== {e.we, e.addr, e.rdata, e.err}) begin
              errors++;
              $display("FAIL rsp_data: got we=%0b addr=%h rdata=%h err=%0b, required we=%0b addr=%h rdata=%h err=%0b",
                       rsp_we, rsp_addr, rsp_rdata, rsp_err, e.we, e.addr, e.rdata, e.err);
            end
          end
        end
        rsp_prev = rsp_valid;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Called just after a negedge; returns just after the negedge following the push edge.
  task automatic push_req(input logic we, input logic [7:0] a, input logic [7:0] d, input logic tmo);
    int n;
    exp_t e;
    n         = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      errors++;
      checks++;
      $display("FAIL push_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
    end else begin
      e.we   = we;
      e.addr = a;
      e.err  = tmo;
      if (tmo) begin
        e.rdata = 8'h00;
      end else if (we) begin
        e.rdata   = 8'h00;
        shadow[a] = d;
      end else begin
        e.rdata = shadow[a];
      end
      exp_q.push_back(e);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick();
    while ((busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: busy=%0b pending=%0d, required busy=0 pending=0", name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready, we_sys, cmd_valid_sys, rsp_valid, rsp_we, rsp_err, busy} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%0b we=%0b cv=%0b rv=%0b rwe=%0b err=%0b busy=%0b, required 1,0,0,0,0,0,0",
               req_ready, we_sys, cmd_valid_sys, rsp_valid, rsp_we, rsp_err, busy);
    end
    checks++;
    if ({addr_sys, rsp_addr, rsp_rdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: addr_sys=%h rsp_addr=%h rsp_rdata=%h, required 00", addr_sys, rsp_addr, rsp_rdata);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d, required IDLE", dut.state_q);
    end
  endtask

  task automatic test_write();
    int n;
    ctl_en    = 1'b1;
    ctl_delay = 3;
    push_req(1'b1, 8'h10, 8'hA5, 1'b0);
    checks++;
    if (cmd_valid_sys !== 1'b0) begin
      errors++;
      $display("FAIL write_lat_early: cmd_valid_sys=%0b one cycle after push, required 0", cmd_valid_sys);
    end
    tick();
    checks++;
    if ({cmd_valid_sys, we_sys, addr_sys} !== {1'b1, 1'b1, 8'h10}) begin
      errors++;
      $display("FAIL write_cmd: cv=%0b we=%0b addr=%h, required 1,1,10", cmd_valid_sys, we_sys, addr_sys);
    end
    checks++;
    if (data_sys !== 8'hA5) begin
      errors++;
      $display("FAIL write_data: data_sys=%h, required a5", data_sys);
    end
    n = 0;
    while (!ready_sys && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b0 || cmd_valid_sys !== 1'b1) begin
      errors++;
      $display("FAIL write_ready_cycle: rsp_valid=%0b cv=%0b in ready cycle, required 0,1", rsp_valid, cmd_valid_sys);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || cmd_valid_sys !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp_lat: rsp_valid=%0b cv=%0b after ready, required 1,0", rsp_valid, cmd_valid_sys);
    end
    wait_idle("write");
  endtask

  task automatic test_read();
    int n;
    ctl_en    = 1'b1;
    ctl_delay = 2;
    push_req(1'b0, 8'h10, 8'h3C, 1'b0);
    tick();
    checks++;
    if ({cmd_valid_sys, we_sys} !== 2'b10 || data_sys === 8'h3C) begin
      errors++;
      $display("FAIL read_issue: cv=%0b we=%0b data_sys=%h, required 1,0 and bus not driven with 3c",
               cmd_valid_sys, we_sys, data_sys);
    end
    n = 0;
    while (!ready_sys && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (data_sys !== 8'hA5) begin
      errors++;
      $display("FAIL read_bus: data_sys=%h while controller drives, required a5", data_sys);
    end
    wait_idle("read");
  endtask

  task automatic test_full_fifo();
    ctl_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_req(i[0], 8'h70 + 8'(i), 8'hC0 + 8'(i), 1'b0);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: req_ready=%0b after 5 accepts, required 0", req_ready);
    end
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h71;
    req_wdata = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (req_ready !== 1'b0 || dut.u_fifo.count !== 3'd4) begin
      errors++;
      $display("FAIL full_hold: req_ready=%0b count=%0d, required 0,4", req_ready, dut.u_fifo.count);
    end
    ctl_en    = 1'b1;
    ctl_delay = 0;
    push_req(1'b0, 8'h71, 8'h00, 1'b0);
    wait_idle("full");
  endtask

  task automatic test_stray_ready();
    int seen;
    seen      = 0;
    ctl_stray = 1'b1;
    tick();
    ctl_stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid || cmd_valid_sys) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL stray_ready: activity=%0d busy=%0b state=%0d, required 0,0,IDLE", seen, busy, dut.state_q);
    end
  endtask

  task automatic test_push_pop();
    int n;
    ctl_en = 1'b0;
    push_req(1'b0, 8'h50, 8'h00, 1'b0);
    push_req(1'b0, 8'h51, 8'h00, 1'b0);
    push_req(1'b1, 8'h52, 8'h9E, 1'b0);
    checks++;
    if (dut.u_fifo.count !== 3'd2) begin
      errors++;
      $display("FAIL pushpop_pre: count=%0d, required 2", dut.u_fifo.count);
    end
    ctl_en    = 1'b1;
    ctl_delay = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    tick();
    push_req(1'b0, 8'h52, 8'h00, 1'b0);
    checks++;
    if (dut.u_fifo.count !== 3'd2) begin
      errors++;
      $display("FAIL pushpop_same: count=%0d after simultaneous push and pop, required 2", dut.u_fifo.count);
    end
    wait_idle("pushpop");
  endtask

  task automatic test_back_to_back();
    int  gaps, min_gap, low_run, n;
    logic prev;
    gaps    = 0;
    min_gap = 1000;
    low_run = 0;
    ctl_en  = 1'b0;
    push_req(1'b1, 8'h60, 8'h11, 1'b0);
    push_req(1'b1, 8'h61, 8'h22, 1'b0);
    push_req(1'b0, 8'h60, 8'h00, 1'b0);
    ctl_en    = 1'b1;
    ctl_delay = 1;
    prev = cmd_valid_sys;
    n = 0;
    while (busy && n < 80) begin
      tick();
      n++;
      if (cmd_valid_sys && !prev) begin
        gaps++;
        if (low_run < min_gap) min_gap = low_run;
      end
      low_run = cmd_valid_sys ? 0 : low_run + 1;
      prev = cmd_valid_sys;
    end
    checks++;
    if (gaps != 2 || min_gap < 2) begin
      errors++;
      $display("FAIL b2b_gap: gaps=%0d min_low=%0d, required 2 gaps of at least 2 cycles", gaps, min_gap);
    end
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid();
    ctl_en = 1'b0;
    push_req(1'b0, 8'h22, 8'h00, 1'b0);
    push_req(1'b0, 8'h23, 8'h00, 1'b0);
    push_req(1'b0, 8'h24, 8'h00, 1'b0);
    checks++;
    if (cmd_valid_sys !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: cmd_valid_sys=%0b, required 1", cmd_valid_sys);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cmd_valid_sys, busy, req_ready} !== 3'b001 || dut.u_fifo.count !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_async: cv=%0b busy=%0b ready=%0b count=%0d, required 0,0,1,0",
               cmd_valid_sys, busy, req_ready, dut.u_fifo.count);
    end
    exp_q.delete();
    tick();
    reset     = 1'b0;
    ctl_en    = 1'b1;
    ctl_delay = 1;
    push_req(1'b0, 8'h42, 8'h00, 1'b0);
    wait_idle("rstmid");
  endtask

`ifdef SYS_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    ctl_en = 1'b0;
    push_req(1'b0, 8'h31, 8'h00, 1'b1);
    tick();
    n = 0;
    while (cmd_valid_sys && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL tmo_cycles: cmd_valid_sys high %0d cycles, required 8", n);
    end
    wait_idle("tmo_expire");
    ctl_en    = 1'b1;
    ctl_delay = 7;
    push_req(1'b0, 8'h31, 8'h00, 1'b0);
    wait_idle("tmo_edge");
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      ctl_mem[i] = 8'(i) ^ 8'h5A;
      shadow[i]  = 8'(i) ^ 8'h5A;
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    ctl_en    = 1'b0;
    ctl_stray = 1'b0;
    ctl_delay = 0;
    test_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_write();
    test_read();
    test_stray_ready();
    test_full_fifo();
    test_push_pop();
    test_back_to_back();
    test_reset_mid();
`ifdef SYS_CMD_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
